// File: rtl/mod_exp_ctrl.sv
// 8-bit modular exponentiation controller: left-to-right square-and-multiply; every mod on an external divider.
// Latency 9+popcount(exponent) divider round trips; stalls in ISSUE while div_ready=0; start ignored while busy.
module mod_exp_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  base,
  input  logic [7:0]  exponent,
  input  logic [7:0]  modulus,
  output logic        ready,
  output logic        done,
  output logic [7:0]  result,
  output logic        error,
  output logic        div_start,
  output logic [15:0] div_dividend,
  output logic [15:0] div_divisor,
  input  logic        div_ready,
  input  logic [15:0] div_remainder
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, STEP, FINISH} state_t;
  typedef enum logic [1:0] {OP_RED, OP_SQR, OP_MUL} op_t;

  state_t     state, state_nxt;
  op_t        op_q;
  logic [7:0] exp_q, b_q, acc_q;
  logic [2:0] bit_q;
  logic       wait_first;
  logic       accept;
  logic       last_op;
  logic [7:0] rem_lo;

  // Remainder is below the 8-bit divisor, so the upper byte is always zero.
  assign rem_lo  = div_remainder[7:0] | (div_remainder[15:8] & 8'h00);
  assign last_op = (bit_q == 3'd0) &&
                   ((op_q == OP_MUL) || ((op_q == OP_SQR) && !exp_q[0]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    done      = 1'b0;
    div_start = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = (modulus == 8'd0) ? FINISH : ISSUE;
        end
      end
      ISSUE: begin
        if (div_ready) begin
          div_start = 1'b1;
          state_nxt = WAIT;
        end
      end
      // The divider only drops ready one edge after start, so its first-cycle ready is stale.
      WAIT:   if (!wait_first && div_ready) state_nxt = STEP;
      STEP:   state_nxt = last_op ? FINISH : ISSUE;
      FINISH: begin
        ready     = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q         <= OP_RED;
      exp_q        <= 8'd0;
      b_q          <= 8'd0;
      acc_q        <= 8'd0;
      bit_q        <= 3'd7;
      wait_first   <= 1'b0;
      result       <= 8'd0;
      error        <= 1'b0;
      div_dividend <= 16'd0;
      div_divisor  <= 16'd0;
    end else begin
      wait_first <= div_start;
      if (accept) begin
        exp_q        <= exponent;
        acc_q        <= (modulus > 8'd1) ? 8'd1 : 8'd0;
        op_q         <= OP_RED;
        bit_q        <= 3'd7;
        result       <= 8'd0;
        error        <= (modulus == 8'd0);
        div_dividend <= {8'd0, base};
        div_divisor  <= {8'd0, modulus};
      end
      if (state == WAIT && state_nxt == STEP) begin
        if (op_q == OP_RED) b_q   <= rem_lo;
        else                acc_q <= rem_lo;
      end
      if (state == STEP) begin
        if (last_op) begin
          result <= acc_q;
        end else if (op_q == OP_SQR && exp_q[bit_q]) begin
          op_q         <= OP_MUL;
          div_dividend <= {8'd0, acc_q} * {8'd0, b_q};
        end else begin
          // Base reduction leads straight into the square for bit 7.
          op_q         <= OP_SQR;
          if (op_q != OP_RED) bit_q <= bit_q - 3'd1;
          div_dividend <= {8'd0, acc_q} * {8'd0, acc_q};
        end
      end
    end
  end

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Bench for mod_exp_ctrl: behavioural divider with random latency, reference by repeated multiplication.
module tb_mod_exp_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  base = 8'd0, exponent = 8'd0, modulus = 8'd0;
  logic        ready, done, error, div_start, div_ready;
  logic [7:0]  result;
  logic [15:0] div_dividend, div_divisor, div_remainder;

  logic        dv_rdy;
  logic        stall = 1'b0;
  int          stall_left = 0;
  int          stall_at = 0;
  int          pulse_cnt = 0;
  int          divisor_bad = 0;
  logic [7:0]  cur_mod = 8'd0;
  int          errors = 0;
  int          checks = 0;

  assign div_ready = dv_rdy & ~stall;

  always #5 clk = ~clk;

  mod_exp_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base(base), .exponent(exponent),
    .modulus(modulus), .ready(ready), .done(done), .result(result), .error(error),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_ready(div_ready), .div_remainder(div_remainder)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_modexp(input logic [7:0] b, input logic [7:0] e, input logic [7:0] m);
    int r;
    if (m == 8'd0) return 8'd0;
    r = 1 % int'(m);
    for (int k = 0; k < int'(e); k++) r = (r * int'(b)) % int'(m);
    return r[7:0];
  endfunction

  // Serial divider: drops ready one edge after start, answers 1-4 edges later, ignores the controller's reset.
  initial begin
    logic        s;
    logic [15:0] dd, dv, dq, vq;
    int          cnt;
    bit          arm;
    dv_rdy = 1'b1; div_remainder = 16'd0; cnt = 0; arm = 1'b0; dq = 16'd0; vq = 16'd1;
    forever begin
      @(posedge clk);
      s = div_start; dd = div_dividend; dv = div_divisor;
      #1;
      if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) stall = 1'b0;
      end
      if (arm) begin
        arm = 1'b0;
        if (stall_at != 0 && pulse_cnt == stall_at) begin
          stall = 1'b1;
          stall_left = 6;
        end
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          dv_rdy = 1'b1;
          div_remainder = dq % vq;
          arm = 1'b1;
        end
      end else if (s) begin
        pulse_cnt++;
        if (dv !== {8'h00, cur_mod}) divisor_bad++;
        dq = dd;
        vq = (dv == 16'd0) ? 16'd1 : dv;
        dv_rdy = 1'b0;
        cnt = $urandom_range(1, 4);
      end
    end
  end

  task automatic run_op(input logic [7:0] b, input logic [7:0] e, input logic [7:0] m,
                        input bit noisy, input int st_at);
    logic [7:0]  er;
    logic [15:0] snap;
    int          ep, sn, sbad;
    bit          got;
    er = ref_modexp(b, e, m);
    ep = (m == 8'd0) ? 0 : 9 + $countones(e);
    @(negedge clk);
    base = b; exponent = e; modulus = m; cur_mod = m;
    pulse_cnt = 0; divisor_bad = 0; stall_at = st_at; start = 1'b1;
    @(negedge clk);
    if (m == 8'd0) check("zero_mod_done_next", done, 1);
    else           check("ready_drop", ready, 0);
    got = done; sn = 0; sbad = 0; snap = 16'd0;
    for (int c = 0; c < 3000 && !got; c++) begin
      if (noisy) begin
        start = 1'($urandom_range(0, 1));
        base = 8'($urandom); exponent = 8'($urandom); modulus = 8'($urandom);
      end else start = 1'b0;
      @(negedge clk);
      if (stall) begin
        sn++;
        if (div_start) sbad++;
        if (sn == 2) snap = div_dividend;
        else if (sn > 2 && div_dividend !== snap) sbad++;
      end
      got = done;
    end
    check("done_seen", got, 1);
    check("result", result, er);
    check("error", error, m == 8'd0);
    check("ready_with_done", ready, 1);
    check("div_pulses", pulse_cnt, ep);
    check("divisor_value", divisor_bad, 0);
    if (st_at != 0) begin
      check("stall_cycles", sn, 6);
      check("stall_quiet_stable", sbad, 0);
    end
    start = 1'b0; stall_at = 0;
    @(negedge clk);
    check("done_one_cycle_idle", {done, ready}, 2'b01);
  endtask

  initial begin
    bit found;
    logic [7:0] rm;
    #3;
    check("reset_outputs_async",
          {ready, done, result, error, div_start, div_dividend, div_divisor}, 44'h800_0000_0000);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(8'd5, 8'd3, 8'd13, 1'b0, 0);
    run_op(8'd7, 8'd255, 8'd11, 1'b0, 0);
    run_op(8'd9, 8'd0, 8'd7, 1'b0, 0);
    run_op(8'd200, 8'd77, 8'd1, 1'b0, 0);
    run_op(8'd33, 8'd5, 8'd0, 1'b0, 0);
    run_op(8'd7, 8'd255, 8'd11, 1'b0, 4);
    run_op(8'd5, 8'd3, 8'd13, 1'b1, 0);

    // Reset while waiting on the divider, then a fresh operation.
    @(negedge clk);
    base = 8'd5; exponent = 8'd3; modulus = 8'd13; cur_mod = 8'd13; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 500 && !found; c++) begin
      @(negedge clk);
      found = (pulse_cnt >= 2) && !div_ready;
    end
    check("reached_wait", found, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_mid_wait_outputs",
          {ready, done, result, error, div_start, div_dividend, div_divisor}, 44'h800_0000_0000);
    found = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done) found = 1'b1;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done) found = 1'b1;
    end
    check("no_done_after_abandon", found, 0);
    run_op(8'd5, 8'd3, 8'd13, 1'b0, 0);

    // Start held across done: not taken in the done cycle, taken on the next edge.
    @(negedge clk);
    base = 8'd3; exponent = 8'd4; modulus = 8'd17; cur_mod = 8'd17; start = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 3000 && !found; c++) begin
      @(negedge clk);
      found = done;
    end
    check("held_start_done", found, 1);
    check("held_start_result", result, ref_modexp(8'd3, 8'd4, 8'd17));
    @(negedge clk);
    check("no_accept_in_done_cycle", {done, ready}, 2'b01);
    @(negedge clk);
    check("accept_after_done", ready, 0);
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 3000 && !found; c++) begin
      @(negedge clk);
      found = done;
    end
    check("second_held_result", result, ref_modexp(8'd3, 8'd4, 8'd17));
    @(negedge clk);

    for (int i = 0; i < 24; i++) begin
      rm = 8'($urandom);
      if (i % 8 == 3) rm = 8'd0;
      if (i % 8 == 5) rm = 8'd1;
      run_op(8'($urandom), 8'($urandom), rm, (i % 2) == 1, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
